// File: rtl/reorder_queue.sv
// Reorder queue: allocates entries at the tail, accepts out-of-order writebacks,
// retires strictly in order from the head, and flushes on a mispredicted head branch.
module reorder_queue #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              CLOCK_50,
    input  logic              RSTN_N,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [REG_W-1:0]  alloc_reg,
    input  logic [DATA_W-1:0] alloc_addr,
    input  logic              alloc_is_store,
    input  logic              alloc_is_branch,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              wb_mispredict,
    input  logic [IDX_W-1:0]  q_idx,
    output logic              q_done,
    output logic [DATA_W-1:0] q_value,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [REG_W-1:0]  commit_reg,
    output logic [DATA_W-1:0] commit_value,
    output logic [DATA_W-1:0] commit_addr,
    output logic              commit_is_store,
    output logic              commit_is_branch,
    output logic              flush,
    output logic [IDX_W:0]    count
);

    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  mispredict;
    logic [DEPTH-1:0]  is_store;
    logic [DEPTH-1:0]  is_branch;
    logic [REG_W-1:0]  dst   [DEPTH];
    logic [DATA_W-1:0] addr  [DEPTH];
    logic [DATA_W-1:0] value [DEPTH];

    logic flush_pending;
    logic alloc_fire;
    logic commit_fire;
    logic wb_fire;
    logic q_bypass;

    // Handshake and status decode; all terms come from registered state or inputs.
    always_comb begin
        flush_pending = busy[head] & done[head] & mispredict[head];
        commit_valid  = busy[head] & done[head] & ~mispredict[head];
        alloc_ready   = (count != (IDX_W+1)'(DEPTH)) & ~flush_pending;
        alloc_fire    = alloc_valid & alloc_ready;
        commit_fire   = commit_valid & commit_ready;
        wb_fire       = wb_valid & busy[wb_idx] & ~done[wb_idx] & ~flush_pending;
        alloc_idx     = tail;
    end

    // Operand lookup with writeback bypass.
    always_comb begin
        q_bypass = wb_valid & (wb_idx == q_idx) & busy[q_idx];
        q_done   = q_bypass | done[q_idx];
        q_value  = '0;
        if (q_bypass) begin
            q_value = wb_value;
        end else if (done[q_idx]) begin
            q_value = value[q_idx];
        end
    end

    // Head entry presented for retirement, zeroed when not committable.
    always_comb begin
        commit_reg       = '0;
        commit_value     = '0;
        commit_addr      = '0;
        commit_is_store  = 1'b0;
        commit_is_branch = 1'b0;
        if (commit_valid) begin
            commit_reg       = dst[head];
            commit_value     = value[head];
            commit_addr      = addr[head];
            commit_is_store  = is_store[head];
            commit_is_branch = is_branch[head];
        end
    end

    // Control state: pointers, occupancy, per-entry status bits, flush pulse.
    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            busy       <= '0;
            done       <= '0;
            mispredict <= '0;
            flush      <= 1'b0;
        end else begin
            flush <= flush_pending;
            if (flush_pending) begin
                busy       <= '0;
                done       <= '0;
                mispredict <= '0;
                tail       <= head;
                count      <= '0;
            end else begin
                if (wb_fire) begin
                    done[wb_idx]       <= 1'b1;
                    mispredict[wb_idx] <= wb_mispredict & is_branch[wb_idx];
                end
                if (commit_fire) begin
                    busy[head] <= 1'b0;
                    done[head] <= 1'b0;
                    head       <= head + IDX_W'(1);
                end
                if (alloc_fire) begin
                    busy[tail]       <= 1'b1;
                    done[tail]       <= 1'b0;
                    mispredict[tail] <= 1'b0;
                    tail             <= tail + IDX_W'(1);
                end
                count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
            end
        end
    end

    // Payload storage; only read when the owning entry is valid, so it needs no reset.
    always_ff @(posedge CLOCK_50) begin
        if (alloc_fire) begin
            dst[tail]       <= alloc_reg;
            addr[tail]      <= alloc_addr;
            is_store[tail]  <= alloc_is_store;
            is_branch[tail] <= alloc_is_branch;
        end
        if (wb_fire) begin
            value[wb_idx] <= wb_value;
        end
    end

endmodule

// File: tb/tb_reorder_queue.sv
// Bench for reorder_queue (DEPTH=4): directed scenarios plus randomized traffic
// checked against an occupancy-window model of the queue.
module tb_reorder_queue;

    localparam int D  = 4;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int IW = 2;

    logic          CLOCK_50 = 1'b0;
    logic          RSTN_N   = 1'b0;
    logic          alloc_valid, alloc_ready, alloc_is_store, alloc_is_branch;
    logic [RW-1:0] alloc_reg;
    logic [DW-1:0] alloc_addr;
    logic [IW-1:0] alloc_idx;
    logic          wb_valid, wb_mispredict;
    logic [IW-1:0] wb_idx;
    logic [DW-1:0] wb_value;
    logic [IW-1:0] q_idx;
    logic          q_done;
    logic [DW-1:0] q_value;
    logic          commit_valid, commit_ready, commit_is_store, commit_is_branch;
    logic [RW-1:0] commit_reg;
    logic [DW-1:0] commit_value, commit_addr;
    logic          flush;
    logic [IW:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: head index plus occupancy; an index is live when inside the window.
    int            m_head, m_count;
    bit            m_flush;
    bit            m_done [D];
    bit            m_mis  [D];
    bit            m_st   [D];
    bit            m_br   [D];
    logic [RW-1:0] m_reg  [D];
    logic [DW-1:0] m_addr [D];
    logic [DW-1:0] m_val  [D];

    reorder_queue #(.DEPTH(D), .DATA_W(DW), .REG_W(RW)) dut (
        .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_reg(alloc_reg),
        .alloc_addr(alloc_addr), .alloc_is_store(alloc_is_store),
        .alloc_is_branch(alloc_is_branch), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict),
        .q_idx(q_idx), .q_done(q_done), .q_value(q_value),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_reg(commit_reg), .commit_value(commit_value), .commit_addr(commit_addr),
        .commit_is_store(commit_is_store), .commit_is_branch(commit_is_branch),
        .flush(flush), .count(count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit in_win(int idx);
        return ((idx - m_head + D) % D) < m_count;
    endfunction

    function automatic bit m_pend();
        return m_count > 0 && m_done[m_head] && m_mis[m_head];
    endfunction

    function automatic bit m_cv();
        return m_count > 0 && m_done[m_head] && !m_mis[m_head];
    endfunction

    function automatic bit m_ar();
        return m_count < D && !m_pend();
    endfunction

    task automatic model_reset();
        m_head = 0; m_count = 0; m_flush = 0;
        for (int i = 0; i < D; i++) begin
            m_done[i] = 0; m_mis[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit pend, cf, af, wok;
        int tl;
        pend = m_pend();
        cf   = m_cv() && commit_ready;
        af   = alloc_valid && m_ar();
        tl   = (m_head + m_count) % D;
        wok  = wb_valid && in_win(int'(wb_idx)) && !m_done[wb_idx] && !pend;
        m_flush = pend;
        if (pend) begin
            m_count = 0;
            for (int i = 0; i < D; i++) begin
                m_done[i] = 0; m_mis[i] = 0;
            end
        end else begin
            if (wok) begin
                m_done[wb_idx] = 1;
                m_val[wb_idx]  = wb_value;
                m_mis[wb_idx]  = wb_mispredict && m_br[wb_idx];
            end
            if (cf) begin
                m_done[m_head] = 0;
                m_head  = (m_head + 1) % D;
                m_count = m_count - 1;
            end
            if (af) begin
                m_reg[tl] = alloc_reg; m_addr[tl] = alloc_addr;
                m_st[tl] = alloc_is_store; m_br[tl] = alloc_is_branch;
                m_done[tl] = 0; m_mis[tl] = 0;
                m_count = m_count + 1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive_idle();
        alloc_valid = 0; alloc_reg = '0; alloc_addr = '0;
        alloc_is_store = 0; alloc_is_branch = 0;
        wb_valid = 0; wb_idx = '0; wb_value = '0; wb_mispredict = 0;
        q_idx = '0; commit_ready = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        RSTN_N = 0;
        @(posedge CLOCK_50);
        #1;
        RSTN_N = 1;
        model_reset();
    endtask

    task automatic do_alloc(input logic [RW-1:0] r, input logic [DW-1:0] a, input logic br);
        alloc_valid = 1; alloc_reg = r; alloc_addr = a; alloc_is_branch = br;
        cycle();
        alloc_valid = 0; alloc_is_branch = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        RSTN_N = 0;
        #3;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
        n_checks++; if (alloc_idx !== 2'd0) begin n_fail++; $display("FAIL reset_alloc_idx: got %0d want 0", alloc_idx); end
        n_checks++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_commit_flush: got %b%b want 00", commit_valid, flush); end
        @(posedge CLOCK_50);
        #1;
        RSTN_N = 1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            alloc_valid = 1; alloc_reg = RW'(i + 1); alloc_addr = DW'(32'h100 + i);
            #1;
            n_checks++; if (alloc_idx !== IW'(i) || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_idx%0d: got idx %0d ready %b want idx %0d ready 1", i, alloc_idx, alloc_ready, i); end
            cycle();
        end
        alloc_reg = 5'd5;
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
        n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", alloc_ready); end
        cycle();
        alloc_valid = 0;
        #1;
        n_checks++; if (count !== 3'd4 || alloc_idx !== 2'd0) begin n_fail++; $display("FAIL fill_fifth_rejected: got count %0d idx %0d want 4 0", count, alloc_idx); end
    endtask

    task automatic test_inorder();
        commit_ready = 1;
        wb_valid = 1; wb_idx = 2; wb_value = 7;
        #1;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_idx2_only: got %b want 0", commit_valid); end
        cycle();
        wb_idx = 0; wb_value = 5;
        #1;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_wb_head_same_cycle: got %b want 0", commit_valid); end
        cycle();
        wb_valid = 0;
        #1;
        n_checks++; if (commit_valid !== 1'b1 || commit_reg !== 5'd1 || commit_value !== 32'd5 || commit_addr !== 32'h100)
            begin n_fail++; $display("FAIL inorder_commit0: got v%b reg %0d val %0d addr %h want v1 reg 1 val 5 addr 100", commit_valid, commit_reg, commit_value, commit_addr); end
        cycle();
        n_checks++; if (commit_valid !== 1'b0 || count !== 3'd3) begin n_fail++; $display("FAIL inorder_block_idx1: got v%b count %0d want v0 count 3", commit_valid, count); end
        cycle();
        n_checks++; if (commit_valid !== 1'b0 || commit_reg !== 5'd0) begin n_fail++; $display("FAIL inorder_still_blocked: got v%b reg %0d want v0 reg 0", commit_valid, commit_reg); end
        wb_valid = 1; wb_idx = 1; wb_value = 6;
        cycle();
        wb_valid = 0;
        #1;
        n_checks++; if (commit_valid !== 1'b1 || commit_reg !== 5'd2 || commit_value !== 32'd6) begin n_fail++; $display("FAIL inorder_commit1: got v%b reg %0d val %0d want v1 reg 2 val 6", commit_valid, commit_reg, commit_value); end
        cycle();
        n_checks++; if (commit_valid !== 1'b1 || commit_reg !== 5'd3 || commit_value !== 32'd7) begin n_fail++; $display("FAIL inorder_commit2: got v%b reg %0d val %0d want v1 reg 3 val 7", commit_valid, commit_reg, commit_value); end
        cycle();
        n_checks++; if (commit_valid !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL inorder_drained: got v%b count %0d want v0 count 1", commit_valid, count); end
        commit_ready = 0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) do_alloc(RW'(6 + i), DW'(32'h200 + i), 1'b0);
        #1;
        n_checks++; if (count !== 3'd4 || alloc_idx !== 2'd3) begin n_fail++; $display("FAIL wrap_refill: got count %0d idx %0d want 4 3", count, alloc_idx); end
        wb_valid = 1; wb_idx = 3; wb_value = 9;
        cycle();
        wb_valid = 0;
        commit_ready = 1; alloc_valid = 1; alloc_reg = 5'd9; alloc_addr = 32'h203;
        #1;
        n_checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_full_no_alloc: got ready %b cv %b want 0 1", alloc_ready, commit_valid); end
        cycle();
        commit_ready = 0; alloc_valid = 0;
        wb_valid = 1; wb_idx = 0; wb_value = 10;
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL wrap_commit_only: got %0d want 3", count); end
        cycle();
        wb_valid = 0;
        commit_ready = 1; alloc_valid = 1;
        #1;
        n_checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 2'd3 || commit_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pre_both: got ready %b idx %0d cv %b want 1 3 1", alloc_ready, alloc_idx, commit_valid); end
        cycle();
        alloc_reg = 5'd10; alloc_addr = 32'h204;
        #1;
        n_checks++; if (count !== 3'd3 || alloc_idx !== 2'd0) begin n_fail++; $display("FAIL wrap_both_same_cycle: got count %0d idx %0d want 3 0", count, alloc_idx); end
        cycle();
        alloc_valid = 0; commit_ready = 0;
        #1;
        n_checks++; if (count !== 3'd4 || alloc_idx !== 2'd1) begin n_fail++; $display("FAIL wrap_alloc_idx0: got count %0d idx %0d want 4 1", count, alloc_idx); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        for (int i = 0; i < D; i++) do_alloc(RW'(i + 1), DW'(32'h300 + i), (i == 1));
        wb_valid = 1; wb_idx = 1; wb_value = 32'h55; wb_mispredict = 1;
        cycle();
        wb_idx = 0; wb_value = 1;
        #1;
        n_checks++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL mis_before_head: got cv %b flush %b want 0 0", commit_valid, flush); end
        cycle();
        wb_valid = 0; wb_mispredict = 0; commit_ready = 1;
        #1;
        n_checks++; if (commit_valid !== 1'b1 || commit_reg !== 5'd1 || commit_is_branch !== 1'b0) begin n_fail++; $display("FAIL mis_head_commit: got cv %b reg %0d br %b want 1 1 0", commit_valid, commit_reg, commit_is_branch); end
        cycle();
        wb_valid = 1; wb_idx = 2; wb_value = 32'h77;
        #1;
        n_checks++; if (commit_valid !== 1'b0 || alloc_ready !== 1'b0 || flush !== 1'b0 || count !== 3'd3)
            begin n_fail++; $display("FAIL mis_pending: got cv %b ready %b flush %b count %0d want 0 0 0 3", commit_valid, alloc_ready, flush, count); end
        cycle();
        wb_valid = 0; q_idx = 2;
        #1;
        n_checks++; if (flush !== 1'b1 || count !== 3'd0 || alloc_idx !== 2'd1 || alloc_ready !== 1'b1 || commit_valid !== 1'b0)
            begin n_fail++; $display("FAIL mis_flush: got flush %b count %0d idx %0d ready %b cv %b want 1 0 1 1 0", flush, count, alloc_idx, alloc_ready, commit_valid); end
        n_checks++; if (q_done !== 1'b0) begin n_fail++; $display("FAIL mis_wb_ignored: got q_done %b want 0", q_done); end
        cycle();
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL mis_flush_one_cycle: got %b want 0", flush); end
        commit_ready = 0;
        do_alloc(5'd5, 32'h400, 1'b0);
        #1;
        n_checks++; if (count !== 3'd1 || alloc_idx !== 2'd2) begin n_fail++; $display("FAIL mis_realloc: got count %0d idx %0d want 1 2", count, alloc_idx); end
    endtask

    task automatic test_bypass();
        do_alloc(5'd6, 32'h401, 1'b0);
        do_alloc(5'd7, 32'h402, 1'b0);
        q_idx = 2;
        #1;
        n_checks++; if (q_done !== 1'b0 || q_value !== 32'd0) begin n_fail++; $display("FAIL byp_not_done: got %b %h want 0 0", q_done, q_value); end
        wb_valid = 1; wb_idx = 3; wb_value = 32'hDEAD; q_idx = 3;
        #1;
        n_checks++; if (q_done !== 1'b1 || q_value !== 32'hDEAD) begin n_fail++; $display("FAIL byp_same_cycle: got %b %h want 1 dead", q_done, q_value); end
        cycle();
        wb_valid = 0;
        #1;
        n_checks++; if (q_done !== 1'b1 || q_value !== 32'hDEAD) begin n_fail++; $display("FAIL byp_stored: got %b %h want 1 dead", q_done, q_value); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_alloc(5'd1, 32'h500, 1'b1);
        do_alloc(5'd2, 32'h501, 1'b0);
        do_alloc(5'd3, 32'h502, 1'b0);
        wb_valid = 1; wb_idx = 0; wb_value = 32'h1; wb_mispredict = 1;
        cycle();
        wb_valid = 0; wb_mispredict = 0;
        #1;
        n_checks++; if (alloc_ready !== 1'b0 || count !== 3'd3) begin n_fail++; $display("FAIL rmid_pending: got ready %b count %0d want 0 3", alloc_ready, count); end
        RSTN_N = 0;
        #1;
        n_checks++; if (count !== 3'd0 || flush !== 1'b0 || commit_valid !== 1'b0 || alloc_ready !== 1'b1)
            begin n_fail++; $display("FAIL rmid_async: got count %0d flush %b cv %b ready %b want 0 0 0 1", count, flush, commit_valid, alloc_ready); end
        @(posedge CLOCK_50);
        #1;
        RSTN_N = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (flush !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rmid_no_flush%0d: got flush %b count %0d want 0 0", i, flush, count); end
            cycle();
        end
    endtask

    task automatic test_random();
        bit            e_qd;
        logic [DW-1:0] e_qv;
        logic [70:0]   e_cm;
        int            tl;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            alloc_valid     = ($urandom_range(0, 9) < 6);
            alloc_reg       = RW'($urandom);
            alloc_addr      = $urandom;
            alloc_is_store  = $urandom_range(0, 1) == 1;
            alloc_is_branch = $urandom_range(0, 2) == 0;
            wb_valid        = $urandom_range(0, 1) == 1;
            wb_idx          = IW'($urandom);
            wb_value        = $urandom;
            wb_mispredict   = $urandom_range(0, 3) == 0;
            q_idx           = IW'($urandom);
            commit_ready    = $urandom_range(0, 3) != 0;
            #1;
            tl   = (m_head + m_count) % D;
            e_qd = 0; e_qv = '0;
            if (in_win(int'(q_idx)) && wb_valid && wb_idx == q_idx) begin
                e_qd = 1; e_qv = wb_value;
            end else if (in_win(int'(q_idx)) && m_done[q_idx]) begin
                e_qd = 1; e_qv = m_val[q_idx];
            end
            e_cm = '0;
            if (m_cv()) e_cm = {m_reg[m_head], m_val[m_head], m_addr[m_head], m_st[m_head], m_br[m_head]};
            n_checks++; if (count !== (IW+1)'(m_count)) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, m_count); end
            n_checks++; if (alloc_ready !== m_ar()) begin n_fail++; $display("FAIL rnd_alloc_ready@%0d: got %b want %b", n, alloc_ready, m_ar()); end
            n_checks++; if (alloc_idx !== IW'(tl)) begin n_fail++; $display("FAIL rnd_alloc_idx@%0d: got %0d want %0d", n, alloc_idx, tl); end
            n_checks++; if (commit_valid !== m_cv()) begin n_fail++; $display("FAIL rnd_commit_valid@%0d: got %b want %b", n, commit_valid, m_cv()); end
            n_checks++; if ({commit_reg, commit_value, commit_addr, commit_is_store, commit_is_branch} !== e_cm)
                begin n_fail++; $display("FAIL rnd_commit_data@%0d: got %h want %h", n, {commit_reg, commit_value, commit_addr, commit_is_store, commit_is_branch}, e_cm); end
            n_checks++; if (flush !== m_flush) begin n_fail++; $display("FAIL rnd_flush@%0d: got %b want %b", n, flush, m_flush); end
            n_checks++; if (q_done !== e_qd || q_value !== e_qv) begin n_fail++; $display("FAIL rnd_lookup@%0d: got %b %h want %b %h", n, q_done, q_value, e_qd, e_qv); end
            cycle();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_fill();
        test_inorder();
        test_wrap();
        test_mispredict();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
